ycr_wb_dmem_arb: RTL and testbench
==================================

// Module: ycr_wb_dmem_arb
// PURPOSE
//  2-master round-robin Wishbone arbiter feeding one burst-capable data bus (bl/bry/lack) in wb_clk.
//  m0 = data-memory WB bridge master; m1 = secondary master (DMA/debug).
//  Grant held for a whole burst; released on last-ack, error or master cyc drop.
// PARAMETERS
//  AW      32    address width
//  DW      32    data width
//  BLW     10    burst-length width (= YCR_WB_BL_DMEM)
//  TMO_CYC 1023  timeout in cycles without ack (YCR_WB_ARB_TMO_EN only)
// PORTS (mN_ = m0_ and m1_, identical sets)
//  wb_clk      in   1      wishbone clock, all logic rising-edge
//  wb_rst      in   1      synchronous active-high reset
//  mN_cyc_i    in   1      master cycle
//  mN_stb_i    in   1      master strobe
//  mN_adr_i    in   AW     address
//  mN_we_i     in   1      write enable
//  mN_dat_i    in   DW     write data
//  mN_sel_i    in   4      byte enables
//  mN_bl_i     in   BLW    burst length (beats)
//  mN_bry_i    in   1      burst ready
//  mN_dat_o    out  DW     read data (= s_dat_i, shared)
//  mN_ack_o    out  1      ack, gated by grant
//  mN_lack_o   out  1      last ack, gated by grant
//  mN_err_o    out  1      error, gated by grant
//  s_cyc_o/s_stb_o/s_we_o/s_bry_o  out  1     granted master's controls
//  s_adr_o  out AW; s_dat_o out DW; s_sel_o out 4; s_bl_o out BLW  granted master's fields
//  s_dat_i  in DW; s_ack_i/s_lack_i/s_err_i in 1   slave response
//  gnt_o       out  2      one-hot grant {m1,m0}; 2'b00 when idle
// BEHAVIOUR
//  - FSM IDLE, GNT0, GNT1; registered; reset -> IDLE, last_gnt=1 (m0 wins first tie).
//  - Req_N = mN_cyc_i & mN_stb_i. IDLE: one req -> its GNT; both -> master != last_gnt; none -> stay.
//  - Arbitration latency 1 cycle: req sampled in IDLE, s_* driven from cycle after.
//  - GNTx: all s_* outputs combinational mux of master x; other master sees ack/lack/err=0.
//  - IDLE: s_cyc/stb/we/bry=0, s_adr/dat/sel/bl=0, gnt_o=0. Same values in/after reset.
//  - GNTx exit (-> IDLE, last_gnt<=x): s_ack_i&s_lack_i, or s_err_i, or mx_cyc_i=0.
//  - Single beat: slave asserts ack+lack together. Burst: ack per beat, lack on final.
//  - Always one IDLE cycle between grants; no same-cycle regrant (guarantees RR alternation).
//  - Response arriving in IDLE is dropped (no mN_ack_o).
//  - mx_cyc_i drop mid-burst: s_cyc_o falls same cycle (comb); FSM -> IDLE next edge.
//  - wb_rst mid-burst: s_cyc_o=0 after that edge; in-flight burst abandoned; slave must tolerate cyc drop.
// CONFIGURATION
//  YCR_WB_ARB_TMO_EN defined: 16-bit cnt clears on grant and each s_ack_i, else +1 in GNTx.
//   cnt==TMO_CYC -> mx_err_o=1 for 1 cycle, s_cyc_o/s_stb_o=0, -> IDLE, last_gnt<=x.
//   Timeout has priority over simultaneous s_ack_i (ack not forwarded).
//  Undefined: no counter; err only from s_err_i; a hung slave holds the grant forever.
// TESTING
//  1 reset, m0/m1 idle -> gnt_o=00, all s_* zero, mN_ack_o=0.
//  2 m0 and m1 single reads same cycle -> m0 granted cycle+1, lack; 1 IDLE; m1 granted; rdata routed.
//  3 m1 burst bl=4, m0 requests mid-burst -> m1 keeps grant for 4 acks; m0 granted 2 cycles after lack.
//  4 s_err_i on beat 2 of m0 burst bl=8 -> m0_err_o=1, FSM IDLE next edge, m1 wins next tie.
//  5 wb_rst high during m0 burst -> s_cyc_o=0 after edge, gnt_o=00, next tie goes to m0.
//  6 TMO_EN, TMO_CYC=16, slave never acks -> m0_err_o pulse 16 cycles after grant, s_cyc_o=0.

Source files
------------

// File: rtl/ycr_wb_dmem_arb.sv
// Two-master round-robin Wishbone arbiter in front of one burst-capable data bus.
// Optional hung-slave timeout: define YCR_WB_ARB_TMO_EN.
module ycr_wb_dmem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BLW     = 10
`ifdef YCR_WB_ARB_TMO_EN
 ,parameter int TMO_CYC = 1023
`endif
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  input  logic           m0_cyc_i,
  input  logic           m0_stb_i,
  input  logic [AW-1:0]  m0_adr_i,
  input  logic           m0_we_i,
  input  logic [DW-1:0]  m0_dat_i,
  input  logic [3:0]     m0_sel_i,
  input  logic [BLW-1:0] m0_bl_i,
  input  logic           m0_bry_i,
  output logic [DW-1:0]  m0_dat_o,
  output logic           m0_ack_o,
  output logic           m0_lack_o,
  output logic           m0_err_o,
  input  logic           m1_cyc_i,
  input  logic           m1_stb_i,
  input  logic [AW-1:0]  m1_adr_i,
  input  logic           m1_we_i,
  input  logic [DW-1:0]  m1_dat_i,
  input  logic [3:0]     m1_sel_i,
  input  logic [BLW-1:0] m1_bl_i,
  input  logic           m1_bry_i,
  output logic [DW-1:0]  m1_dat_o,
  output logic           m1_ack_o,
  output logic           m1_lack_o,
  output logic           m1_err_o,
  output logic           s_cyc_o,
  output logic           s_stb_o,
  output logic           s_we_o,
  output logic           s_bry_o,
  output logic [AW-1:0]  s_adr_o,
  output logic [DW-1:0]  s_dat_o,
  output logic [3:0]     s_sel_o,
  output logic [BLW-1:0] s_bl_o,
  input  logic [DW-1:0]  s_dat_i,
  input  logic           s_ack_i,
  input  logic           s_lack_i,
  input  logic           s_err_i,
  output logic [1:0]     gnt_o
);

  typedef struct packed {
    logic           cyc;
    logic           stb;
    logic           we;
    logic           bry;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat;
    logic [3:0]     sel;
    logic [BLW-1:0] bl;
  } mreq_t;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

  state_t      state, nxt;
  logic        last_gnt, nxt_last;
  mreq_t [1:0] mreq;
  mreq_t       s_bus;
  logic  [1:0] req, m_ack, m_lack, m_err;
  logic        sel_m, granted, tmo_hit, end_c;

  assign mreq[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_bry_i, m0_adr_i, m0_dat_i, m0_sel_i, m0_bl_i};
  assign mreq[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_bry_i, m1_adr_i, m1_dat_i, m1_sel_i, m1_bl_i};
  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign granted = (state != IDLE);
  assign sel_m   = (state == GNT1);

`ifdef YCR_WB_ARB_TMO_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !granted || s_ack_i) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = granted && (tmo_cnt == 16'(TMO_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  assign end_c = (s_ack_i & s_lack_i) | s_err_i | ~mreq[sel_m].cyc | tmo_hit;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= nxt;
      last_gnt <= nxt_last;
    end
  end

  always_comb begin
    nxt      = state;
    nxt_last = last_gnt;
    s_bus    = '0;
    m_ack    = '0;
    m_lack   = '0;
    m_err    = '0;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) nxt = last_gnt ? GNT0 : GNT1;
        else if (req[0])      nxt = GNT0;
        else if (req[1])      nxt = GNT1;
      end
      GNT0, GNT1: begin
        // Exit always passes through IDLE so the other master gets its turn.
        if (end_c) begin
          nxt      = IDLE;
          nxt_last = sel_m;
        end
        s_bus = mreq[sel_m];
        if (tmo_hit) begin
          s_bus.cyc = 1'b0;
          s_bus.stb = 1'b0;
        end
        m_ack[sel_m]  = s_ack_i & ~tmo_hit;
        m_lack[sel_m] = s_lack_i & ~tmo_hit;
        m_err[sel_m]  = s_err_i | tmo_hit;
      end
      default: nxt = IDLE;
    endcase
  end

  assign s_cyc_o   = s_bus.cyc;
  assign s_stb_o   = s_bus.stb;
  assign s_we_o    = s_bus.we;
  assign s_bry_o   = s_bus.bry;
  assign s_adr_o   = s_bus.adr;
  assign s_dat_o   = s_bus.dat;
  assign s_sel_o   = s_bus.sel;
  assign s_bl_o    = s_bus.bl;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = m_ack[0];
  assign m1_ack_o  = m_ack[1];
  assign m0_lack_o = m_lack[0];
  assign m1_lack_o = m_lack[1];
  assign m0_err_o  = m_err[0];
  assign m1_err_o  = m_err[1];
  assign gnt_o     = state;

endmodule

// File: tb/tb_ycr_wb_dmem_arb.sv
// Randomized bench for ycr_wb_dmem_arb: two master agents, a slave agent with a response
// scoreboard, and a rule-based arbitration/routing checker.
module tb_ycr_wb_dmem_arb;
  localparam int AW = 32, DW = 32, BLW = 10;

  typedef struct packed {
    logic           cyc;
    logic           stb;
    logic           we;
    logic           bry;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat;
    logic [3:0]     sel;
    logic [BLW-1:0] bl;
  } req_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          e;
  } rsp_t;

  logic clk = 1'b0, rst = 1'b1;
  req_t m_rq [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_bry_o;
  logic [AW-1:0] s_adr_o;
  logic [3:0] s_sel_o;
  logic [BLW-1:0] s_bl_o;
  logic [DW-1:0] s_dat_i = '0;
  logic s_ack_i = 1'b0, s_lack_i = 1'b0, s_err_i = 1'b0;
  logic [1:0] gnt_o;

  int errors = 0, checks = 0;
  bit mon_en = 1'b1, slave_en = 1'b1, err_en = 1'b1;
  rsp_t q0[$], q1[$];

  ycr_wb_dmem_arb #(.AW(AW), .DW(DW), .BLW(BLW)
`ifdef YCR_WB_ARB_TMO_EN
    , .TMO_CYC(16)
`endif
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .m0_cyc_i(m_rq[0].cyc), .m0_stb_i(m_rq[0].stb), .m0_adr_i(m_rq[0].adr), .m0_we_i(m_rq[0].we),
    .m0_dat_i(m_rq[0].dat), .m0_sel_i(m_rq[0].sel), .m0_bl_i(m_rq[0].bl), .m0_bry_i(m_rq[0].bry),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_lack_o(m0_lack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_rq[1].cyc), .m1_stb_i(m_rq[1].stb), .m1_adr_i(m_rq[1].adr), .m1_we_i(m_rq[1].we),
    .m1_dat_i(m_rq[1].dat), .m1_sel_i(m_rq[1].sel), .m1_bl_i(m_rq[1].bl), .m1_bry_i(m_rq[1].bry),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_lack_o(m1_lack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_bry_o(s_bry_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_bl_o(s_bl_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_lack_i(s_lack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic port_chk(input int m, input logic a, input logic l, input logic e, input logic [DW-1:0] d);
    rsp_t r;
    bit   has = (m == 1) ? (q1.size() > 0) : (q0.size() > 0);
    if (has) begin
      r = (m == 1) ? q1.pop_front() : q0.pop_front();
      chk($sformatf("rsp m%0d", m), a == !r.e && l == r.l && e == r.e && (r.e || d == r.d),
          {a, l, e, d}, {!r.e, r.l, r.e, r.d});
    end else begin
      chk($sformatf("spurious m%0d", m), !(a | l | e), {a, l, e}, 3'b000);
    end
  endtask

  // Slave agent: random wait states, ack per beat, lack on the final beat, rare error,
  // and stray responses while nobody is granted (these must be dropped).
  initial begin
    rsp_t r;
    int   beat = 0;
    forever begin
      @(posedge clk); #2;
      s_ack_i = 1'b0; s_lack_i = 1'b0; s_err_i = 1'b0;
      if (!s_cyc_o) begin
        beat = 0;
        if (slave_en && gnt_o == 2'b00 && $urandom_range(0, 7) == 0) begin
          s_ack_i  = 1'b1;
          s_lack_i = 1'($urandom_range(0, 1));
          s_dat_i  = $urandom;
        end
      end else if (slave_en && s_stb_o && $urandom_range(0, 2) != 0) begin
        r.d = $urandom; r.l = 1'b0; r.e = 1'b0;
        s_dat_i = r.d;
        if (err_en && $urandom_range(0, 19) == 0) begin
          s_err_i = 1'b1; r.e = 1'b1;
        end else begin
          s_ack_i  = 1'b1;
          r.l      = (beat == int'(s_bl_o) - 1);
          s_lack_i = r.l;
          beat++;
        end
        if (gnt_o[1]) q1.push_back(r);
        else          q0.push_back(r);
      end
    end
  end

  // Monitor: response scoreboard plus arbitration rules checked against the previous cycle.
  initial begin
    logic [1:0] p_gnt = 2'b00, e_gnt;
    bit p_r0 = 0, p_r1 = 0, p_end = 0, p_rst = 1, last = 1, have_prev = 0, own;
    logic [81:0] exp_s, act_s;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        port_chk(0, m0_ack_o, m0_lack_o, m0_err_o, m0_dat_o);
        port_chk(1, m1_ack_o, m1_lack_o, m1_err_o, m1_dat_o);
        e_gnt = 2'b00;
        if (have_prev) begin
          if (p_rst) begin
            e_gnt = 2'b00; last = 1'b1;
          end else if (p_gnt == 2'b00) begin
            if (p_r0 && p_r1) e_gnt = last ? 2'b01 : 2'b10;
            else if (p_r0)    e_gnt = 2'b01;
            else if (p_r1)    e_gnt = 2'b10;
          end else if (p_end) begin
            e_gnt = 2'b00; last = p_gnt[1];
          end else begin
            e_gnt = p_gnt;
          end
        end
        chk("gnt", gnt_o == e_gnt, gnt_o, e_gnt);
        exp_s = (e_gnt == 2'b01) ? m_rq[0] : (e_gnt == 2'b10) ? m_rq[1] : '0;
        act_s = {s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_adr_o, s_dat_o, s_sel_o, s_bl_o};
        chk("route", act_s == exp_s, act_s, exp_s);
        own   = e_gnt[1];
        p_gnt = e_gnt;
        p_r0  = m_rq[0].cyc & m_rq[0].stb;
        p_r1  = m_rq[1].cyc & m_rq[1].stb;
        p_end = !m_rq[own].cyc || (s_ack_i && s_lack_i) || s_err_i;
        p_rst = rst;
        have_prev = 1'b1;
      end
    end
  end

  task automatic run_master(input int m, input int n);
    req_t r;
    int   cnt;
    bit   done, fin;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      r.cyc = 1'b1; r.stb = 1'b1;
      r.we  = 1'($urandom_range(0, 1));
      r.bry = 1'($urandom_range(0, 1));
      r.adr = $urandom;
      r.dat = $urandom;
      r.sel = 4'($urandom_range(0, 15));
      r.bl  = 10'($urandom_range(1, 4));
      m_rq[m] = r;
      cnt = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        cnt++;
        fin = (m == 1) ? (m1_lack_o | m1_err_o) : (m0_lack_o | m0_err_o);
        if (fin || cnt > 300) done = 1'b1;
        else if (gnt_o[m] && $urandom_range(0, 49) == 0) done = 1'b1;
      end
      chk($sformatf("m%0d completes", m), cnt <= 300, cnt, 300);
      @(posedge clk); #1;
      m_rq[m] = '0;
    end
  endtask

  initial begin
    int k;
    m_rq[0] = '0; m_rq[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", gnt_o == 2'b00, gnt_o, 0);
    chk("reset s_bus", {s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_adr_o, s_dat_o, s_sel_o, s_bl_o} == '0,
        {s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_adr_o, s_dat_o, s_sel_o, s_bl_o}, 0);
    chk("reset acks", {m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o} == '0,
        {m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fork
      run_master(0, 60);
      run_master(1, 60);
    join

    // Reset in the middle of an m0 burst; afterwards a tie must go to m0.
    err_en = 1'b0;
    m_rq[0] = {1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 4'hF, 10'd8};
    k = 0;
    do begin @(negedge clk); k++; end while (gnt_o != 2'b01 && k < 50);
    chk("burst grant", gnt_o == 2'b01, gnt_o, 2'b01);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    m_rq[1] = {1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h55, 4'h3, 10'd1};
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst drops cyc", s_cyc_o == 1'b0 && gnt_o == 2'b00, {s_cyc_o, gnt_o}, 0);
    @(negedge clk);
    chk("tie after rst", gnt_o == 2'b01, gnt_o, 2'b01);
    @(posedge clk); #1;
    m_rq[0] = '0; m_rq[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    err_en = 1'b1;

`ifdef YCR_WB_ARB_TMO_EN
    // Hung slave: m0 must see one err pulse 16 cycles into its grant.
    mon_en = 1'b0; slave_en = 1'b0;
    m_rq[0] = {1'b1, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 4'hF, 10'd1};
    k = 0;
    do begin @(negedge clk); k++; end while (gnt_o != 2'b01 && k < 20);
    chk("tmo grant", gnt_o == 2'b01, gnt_o, 2'b01);
    k = 0;
    do begin @(negedge clk); k++; end while (!m0_err_o && k < 40);
    chk("tmo latency", k == 16, k, 16);
    chk("tmo bus", {s_cyc_o, s_stb_o, m0_ack_o} == 3'b000, {s_cyc_o, s_stb_o, m0_ack_o}, 0);
    @(posedge clk); #1;
    m_rq[0] = '0;
    @(negedge clk);
    chk("tmo release", gnt_o == 2'b00, gnt_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
